gradient_patch_reader: RTL

- Sequences reads of one SUB_SIZE x SUB_SIZE gradient sub-patch from a single octave/level gradient BRAM pair (x and y share one address).
- Sits between the descriptor controller, which issues a patch origin per sub-patch, and the histogram unit, which consumes the streamed gradient pairs.
- Handles per-octave image width, edge clamping, BRAM read latency and completion signalling, so the descriptor controller only issues start/done handshakes.

---
 rtl/gradient_patch_reader.sv | 97 +++++++++
 1 files changed

// File: rtl/gradient_patch_reader.sv
// gradient_patch_reader: streams one clamped SUB_SIZE x SUB_SIZE gradient sub-patch from BRAM to the histogram unit.
module gradient_patch_reader #(
  parameter int DIMENSION    = 64,
  parameter int BIT_DEPTH    = 8,
  parameter int SUB_SIZE     = 2,
  parameter int READ_LATENCY = 2
) (
  input  logic                                   clk,
  input  logic                                   rst_in,
  input  logic                                   start,
  input  logic [1:0]                             octave,
  input  logic [$clog2(DIMENSION)-1:0]           x0,
  input  logic [$clog2(DIMENSION)-1:0]           y0,
  output logic [$clog2(DIMENSION*DIMENSION)-1:0] grad_addr,
  input  logic signed [BIT_DEPTH-1:0]            grad_x_in,
  input  logic signed [BIT_DEPTH-1:0]            grad_y_in,
  output logic                                   pix_valid,
  output logic signed [BIT_DEPTH-1:0]            pix_gx,
  output logic signed [BIT_DEPTH-1:0]            pix_gy,
  output logic                                   pix_last,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   err
);
  localparam int AW = $clog2(DIMENSION);
  localparam int DW = $clog2(DIMENSION*DIMENSION);
  localparam int SW = SUB_SIZE > 1 ? $clog2(SUB_SIZE) : 1;
  localparam int L  = READ_LATENCY;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t state, nstate;
  logic [AW-1:0] xq, yq, ox, oy;
  logic [1:0] oq, oo;
  logic [SW-1:0] ci, cj, ni, nj;
  logic [AW:0] w, col, row, colc, rowc;
  logic [DW-1:0] addr_n;
  logic [L-1:0] vq, lq;
  logic idle, issue, wrap, last, accept;
  // In IDLE the next address is pixel 0 from the live inputs so it lands in the first ISSUE cycle.
  always_comb begin
    idle   = state == IDLE;
    issue  = state == ISSUE;
    accept = idle && start && octave != 2'd3;
    wrap   = ci == SW'(SUB_SIZE-1);
    last   = issue && wrap && cj == SW'(SUB_SIZE-1);
    ox     = idle ? x0 : xq;
    oy     = idle ? y0 : yq;
    oo     = idle ? octave : oq;
    ni     = idle || wrap ? '0 : ci + 1'b1;
    nj     = idle ? '0 : wrap ? cj + 1'b1 : cj;
    w      = (AW+1)'(DIMENSION) >> oo;
    col    = {1'b0, ox} + (AW+1)'(ni);
    row    = {1'b0, oy} + (AW+1)'(nj);
    colc   = col >= w ? w - 1'b1 : col;
    rowc   = row >= w ? w - 1'b1 : row;
    addr_n = (DW'(rowc) << (AW - oo)) + DW'(colc);
    nstate = idle ? (accept ? ISSUE : IDLE) :
             issue ? (last ? DRAIN : ISSUE) :
             state == DRAIN ? (pix_last ? DONE : DRAIN) : IDLE;
  end
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      state     <= IDLE;
      grad_addr <= '0;
      vq        <= '0;
      lq        <= '0;
      err       <= 1'b0;
      xq        <= '0;
      yq        <= '0;
      oq        <= '0;
      ci        <= '0;
      cj        <= '0;
    end else begin
      state <= nstate;
      vq    <= L'({vq, issue});
      lq    <= L'({lq, last});
      err   <= idle && start && octave == 2'd3;
      if (accept) begin
        xq        <= x0;
        yq        <= y0;
        oq        <= octave;
        ci        <= '0;
        cj        <= '0;
        grad_addr <= addr_n;
      end else if (issue && !last) begin
        ci        <= ni;
        cj        <= nj;
        grad_addr <= addr_n;
      end
    end
  end
  assign pix_valid = vq[L-1];
  assign pix_last  = lq[L-1];
  assign pix_gx    = grad_x_in;
  assign pix_gy    = grad_y_in;
  assign busy      = state != IDLE;
  assign done      = state == DONE;
endmodule
